// File: rtl/regex_dispatch_collect_if.sv
// Bus bundle between the dispatch/collect block and its neighbours.
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where valid and ready are both 1; a source holds valid and
// its payload stable until that edge, and ready may depend combinationally
// on valid-independent state only.
interface regex_dispatch_collect_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int NUM_ENGINES = 16,
    parameter int ENG_BITS    = 4
);
    // job word stream
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    // configuration word stream
    logic [DATA_WIDTH-1:0]  cfg_data;
    logic                   cfg_valid;
    logic                   cfg_ready;
    // dispatch bus to the engines
    logic [DATA_WIDTH-1:0]  eng_data;
    logic                   eng_is_cfg;
    logic [NUM_ENGINES-1:0] eng_valid;
    logic [NUM_ENGINES-1:0] eng_ready;
    // per-engine result return
    logic [NUM_ENGINES-1:0] res_match;
    logic [NUM_ENGINES-1:0] res_valid;
    logic [NUM_ENGINES-1:0] res_ready;
    // in-order result stream
    logic                   found_match;
    logic                   found_valid;
    logic [ENG_BITS-1:0]    found_engine;
    logic                   found_ready;
    // control and status
    logic                   mode_reset;
    logic                   idle;
    logic                   mode_dbg;   // 0 = CONFIG, 1 = SCAN

    modport slave (
        input  in_data, in_valid, in_last, cfg_data, cfg_valid, eng_ready,
               res_match, res_valid, found_ready, mode_reset,
        output in_ready, cfg_ready, eng_data, eng_is_cfg, eng_valid, res_ready,
               found_match, found_valid, found_engine, idle, mode_dbg
    );

    modport master (
        output in_data, in_valid, in_last, cfg_data, cfg_valid, eng_ready,
               res_match, res_valid, found_ready, mode_reset,
        input  in_ready, cfg_ready, eng_data, eng_is_cfg, eng_valid, res_ready,
               found_match, found_valid, found_engine, idle, mode_dbg
    );
endinterface

// File: rtl/regex_dispatch_collect.sv
// Regex engine dispatcher and in-order result collector.
// CONFIG mode deals config words round-robin (or broadcast, which enters
// SCAN); SCAN mode deals jobs round-robin with a per-engine credit limit and
// returns results strictly in dispatch order.
module regex_dispatch_collect #(
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_ENGINES     = 16,
    parameter int ENG_BITS        = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                     clk,
    input logic                     rst,
    regex_dispatch_collect_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        MODE_CONFIG = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    mode_t                  mode;
    logic                   pending;
    logic [ENG_BITS-1:0]    cfg_ptr;
    logic [ENG_BITS-1:0]    in_ptr;
    logic [ENG_BITS-1:0]    out_ptr;
    logic [CNT_W-1:0]       outstanding [NUM_ENGINES];

    logic [NUM_ENGINES-1:0] eng_valid_q;
    logic [DATA_WIDTH-1:0]  eng_data_q;
    logic                   eng_is_cfg_q;

    logic                   stage_free;
    logic                   any_outstanding;
    logic                   idle_w;
    logic                   cfg_ready_w;
    logic                   in_ready_w;
    logic                   cfg_hs;
    logic                   cfg_bcast;
    logic                   in_hs;
    logic                   job_done;
    logic                   found_valid_w;
    logic                   found_hs;
    logic                   go_config;
    logic [NUM_ENGINES-1:0] cnt_inc;
    logic [NUM_ENGINES-1:0] cnt_dec;

    function automatic logic [ENG_BITS-1:0] next_ptr(input logic [ENG_BITS-1:0] p);
        return (p == ENG_BITS'(NUM_ENGINES - 1)) ? '0 : p + ENG_BITS'(1);
    endfunction

    // Stage is free when every engine with a pending word takes it this cycle.
    assign stage_free = &(~eng_valid_q | bus.eng_ready);

    // Any engine still owing a result.
    always_comb begin
        any_outstanding = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (outstanding[i] != '0) any_outstanding = 1'b1;
        end
    end

    assign idle_w      = !any_outstanding && (eng_valid_q == '0);
    assign cfg_ready_w = (mode == MODE_CONFIG) && stage_free;
    assign in_ready_w  = (mode == MODE_SCAN) && stage_free && !pending &&
                         (outstanding[in_ptr] < CNT_W'(MAX_OUTSTANDING));

    assign cfg_hs    = bus.cfg_valid && cfg_ready_w;
    assign cfg_bcast = bus.cfg_data[DATA_WIDTH-1];
    assign in_hs     = bus.in_valid && in_ready_w;
    assign job_done  = in_hs && bus.in_last;

    assign found_valid_w = bus.res_valid[out_ptr];
    assign found_hs      = found_valid_w && bus.found_ready;
    assign go_config     = pending && idle_w;

    // Per-engine credit events; a decrement at zero is dropped.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            cnt_inc[i] = job_done && (in_ptr == ENG_BITS'(i));
            cnt_dec[i] = found_hs && (out_ptr == ENG_BITS'(i)) && (outstanding[i] != '0);
        end
    end

    // Mode FSM, deferred mode return and the three round-robin pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= MODE_CONFIG;
            pending <= 1'b0;
            cfg_ptr <= '0;
            in_ptr  <= '0;
            out_ptr <= '0;
        end else if (go_config) begin
            mode    <= MODE_CONFIG;
            pending <= 1'b0;
            cfg_ptr <= '0;
            in_ptr  <= '0;
            out_ptr <= '0;
        end else begin
            if (bus.mode_reset && (mode == MODE_SCAN)) pending <= 1'b1;
            case (mode)
                MODE_CONFIG: begin
                    if (cfg_hs) begin
                        if (cfg_bcast) begin
                            cfg_ptr <= '0;
                            mode    <= MODE_SCAN;
                        end else begin
                            cfg_ptr <= next_ptr(cfg_ptr);
                        end
                    end
                end
                MODE_SCAN: begin
                    if (job_done) in_ptr <= next_ptr(in_ptr);
                end
                default: mode <= MODE_CONFIG;
            endcase
            if (found_hs) out_ptr <= next_ptr(out_ptr);
        end
    end

    // Outstanding-job counters; a simultaneous inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENGINES; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])
                    outstanding[i] <= outstanding[i] + CNT_W'(1);
                else if (cnt_dec[i] && !cnt_inc[i])
                    outstanding[i] <= outstanding[i] - CNT_W'(1);
            end
        end
    end

    // Dispatch register: load on a handshake, otherwise drain bits as engines take them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_valid_q  <= '0;
            eng_data_q   <= '0;
            eng_is_cfg_q <= 1'b0;
        end else if (cfg_hs) begin
            eng_data_q   <= bus.cfg_data;
            eng_is_cfg_q <= 1'b1;
            eng_valid_q  <= cfg_bcast ? '1 : (NUM_ENGINES'(1) << cfg_ptr);
        end else if (in_hs) begin
            eng_data_q   <= bus.in_data;
            eng_is_cfg_q <= 1'b0;
            eng_valid_q  <= NUM_ENGINES'(1) << in_ptr;
        end else begin
            eng_valid_q  <= eng_valid_q & ~bus.eng_ready;
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.cfg_ready    = cfg_ready_w;
    assign bus.eng_data     = eng_data_q;
    assign bus.eng_is_cfg   = eng_is_cfg_q;
    assign bus.eng_valid    = eng_valid_q;
    assign bus.res_ready    = (NUM_ENGINES'(1) << out_ptr) & {NUM_ENGINES{bus.found_ready}};
    assign bus.found_valid  = found_valid_w;
    assign bus.found_match  = bus.res_match[out_ptr];
    assign bus.found_engine = out_ptr;
    assign bus.idle         = idle_w;
    assign bus.mode_dbg     = (mode == MODE_SCAN);
endmodule
